// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes.
// Single-cycle ops (add/sub/not/and/or/xor/slt/eq) and illegal opcodes complete
// on the accept edge. Shifts move one bit per cycle. The optional shift-add
// multiplier is enabled with `define ALU_SEQ_MUL_EN.
// For iterative ops, the first step happens on the accept edge.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             err
);
  localparam int CW = SHW + 1;
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;   // shift operand, or low product half / multiplier
  logic [CW-1:0]    cnt_q, cnt_d;     // steps remaining, including the current one
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] hi_q, hi_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] sh, sm, nh;
  logic [WIDTH:0]   psum;
`endif

  logic             accept;
  logic [WIDTH:0]   sum, diff;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] c_y;
  logic             c_c, c_v, c_err;
  logic [WIDTH-1:0] sw, nxt;
  logic [CW-1:0]    sc;
  logic [3:0]       sop;
  logic             do_step, bit_o;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign y         = y_q;
  assign flags     = flags_q;
  assign err       = err_q;

  // Single-cycle result straight from the request inputs.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    add_v = (a[M] == b[M]) && (sum[M] != a[M]);
    sub_v = (a[M] != b[M]) && (diff[M] != a[M]);
    c_y   = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    c_err = 1'b0;
    case (opt)
      4'd0: begin c_y = sum[M:0];  c_c = sum[WIDTH];   c_v = add_v; end
      4'd1: begin c_y = diff[M:0]; c_c = ~diff[WIDTH]; c_v = sub_v; end
      4'd2: c_y = ~a;
      4'd3: c_y = a & b;
      4'd4: c_y = a | b;
      4'd5: c_y = a ^ b;
      4'd6: begin
        c_y = {{(WIDTH-1){1'b0}}, diff[M] ^ sub_v};
        c_c = ~diff[WIDTH];
        c_v = sub_v;
      end
      4'd7: c_y = {{(WIDTH-1){1'b0}}, (a == b)};
      default: c_err = 1'b1;
    endcase
  end

  // Next state: launch on accept, iterate in BUSY, hold result in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    flags_d = flags_q;
    err_d   = err_q;
    sw      = work_q;
    sc      = cnt_q;
    sop     = op_q;
    do_step = 1'b0;
    nxt     = work_q;
    bit_o   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    sh      = hi_q;
    sm      = mcand_q;
    psum    = '0;
    nh      = hi_q;
`endif
    if (state_q == BUSY) begin
      do_step = 1'b1;
    end else begin
      if (state_q == DONE && out_ready) state_d = IDLE;
      if (accept) begin
        op_d = opt;
        sop  = opt;
        if (opt == 4'd8 || opt == 4'd9 || opt == 4'd10) begin
          sw = a;
          sc = {1'b0, b[SHW-1:0]};
          if (b[SHW-1:0] == '0) begin
            y_d     = a;
            flags_d = {a[M], (a == '0), 2'b00};
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            do_step = 1'b1;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (opt == 4'd11) begin
          sw      = b;
          sh      = '0;
          sm      = a;
          sc      = CW'(WIDTH);
          do_step = 1'b1;
        end
`endif
        else begin
          y_d     = c_y;
          flags_d = {c_y[M], (c_y == '0), c_c, c_v};
          err_d   = c_err;
          state_d = DONE;
        end
      end
    end

    if (do_step) begin
      case (sop)
        4'd8:  begin nxt = {sw[M-1:0], 1'b0}; bit_o = sw[M]; end
        4'd9:  begin nxt = {1'b0, sw[M:1]};   bit_o = sw[0]; end
        4'd10: begin nxt = {sw[M], sw[M:1]};  bit_o = sw[0]; end
        default: begin
`ifdef ALU_SEQ_MUL_EN
          psum    = {1'b0, sh} + (sw[0] ? {1'b0, sm} : '0);
          nh      = psum[WIDTH:1];
          nxt     = {psum[0], sw[M:1]};
          bit_o   = |nh;
          hi_d    = nh;
          mcand_d = sm;
`endif
        end
      endcase
      work_d = nxt;
      cnt_d  = sc - CW'(1);
      if (sc <= CW'(1)) begin
        y_d     = nxt;
        flags_d = {nxt[M], (nxt == '0), bit_o, 1'b0};
        err_d   = 1'b0;
        state_d = DONE;
      end else begin
        state_d = BUSY;
      end
    end
  end

  // State register; reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [7:0] a, b, y;
  logic [3:0] opt, flags;
  int checks = 0;
  int failures = 0;
  int lat;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opt(opt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, scramble the operands after acceptance, then
  // count cycles until out_valid (bounded).
  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    chk("ready_before", {31'd0, in_ready}, 32'd1);
    opt = op; a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 8'h5C; b = 8'hA7; opt = 4'd3;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input logic [7:0] ey, input logic [3:0] ef,
                            input logic ee, input int elat);
    chk({tag, "_y"},   {24'd0, y}, {24'd0, ey});
    chk({tag, "_fl"},  {28'd0, flags}, {28'd0, ef});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    chk({tag, "_lat"}, lat, elat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opt = '0;
    tick(); tick();
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_fl", {28'd0, flags}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();

    issue(4'd0, 8'h7F, 8'h01);  expect_res("add_ovf", 8'h80, 4'b1001, 1'b0, 1);
    issue(4'd10, 8'h90, 8'h03); expect_res("sra3",    8'hF2, 4'b1000, 1'b0, 3);
    issue(4'd10, 8'h90, 8'h00); expect_res("sra0",    8'h90, 4'b1000, 1'b0, 1);
    issue(4'd8, 8'h81, 8'h01);  expect_res("sll1",    8'h02, 4'b0010, 1'b0, 1);
    issue(4'd9, 8'h06, 8'h02);  expect_res("srl2",    8'h01, 4'b0010, 1'b0, 2);
    issue(4'd8, 8'h01, 8'h0F);  expect_res("sll7",    8'h80, 4'b1000, 1'b0, 7);
    issue(4'd1, 8'h05, 8'h03);  expect_res("sub",     8'h02, 4'b0010, 1'b0, 1);
    issue(4'd6, 8'h80, 8'h01);  expect_res("slt_t",   8'h01, 4'b0011, 1'b0, 1);
    issue(4'd6, 8'h01, 8'h80);  expect_res("slt_f",   8'h00, 4'b0101, 1'b0, 1);
    issue(4'd7, 8'h5A, 8'h5B);  expect_res("eq_f",    8'h00, 4'b0100, 1'b0, 1);
    issue(4'd2, 8'h0F, 8'h00);  expect_res("not",     8'hF0, 4'b1000, 1'b0, 1);
    issue(4'd3, 8'hF0, 8'h3C);  expect_res("and",     8'h30, 4'b0000, 1'b0, 1);
    issue(4'd4, 8'hF0, 8'h0F);  expect_res("or",      8'hFF, 4'b1000, 1'b0, 1);
    issue(4'd5, 8'hAA, 8'hAA);  expect_res("xor",     8'h00, 4'b0100, 1'b0, 1);
    issue(4'd0, 8'hFF, 8'h01);  expect_res("add_c",   8'h00, 4'b0110, 1'b0, 1);
    issue(4'd13, 8'h12, 8'h34); expect_res("illegal", 8'h00, 4'b0100, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
    issue(4'd11, 8'h10, 8'h11); expect_res("mul",     8'h10, 4'b0010, 1'b0, 8);
    issue(4'd11, 8'h0D, 8'h0B); expect_res("mul_lo",  8'h8F, 4'b1000, 1'b0, 8);
`else
    issue(4'd11, 8'h10, 8'h11); expect_res("mul_off", 8'h00, 4'b0100, 1'b1, 1);
`endif
    tick();

    // Back-pressure: hold the result, then restart on the release edge.
    out_ready = 1'b0;
    issue(4'd1, 8'h03, 8'h05);  expect_res("sub_neg", 8'hFE, 4'b1000, 1'b0, 1);
    opt = 4'd0; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ir", {31'd0, in_ready}, 32'd0);
      chk("hold_y", {24'd0, y}, 32'hFE);
      chk("hold_ov", {31'd0, out_valid}, 32'd1);
      tick();
    end
    chk("hold_fl", {28'd0, flags}, 32'b1000);
    out_ready = 1'b1; #1;
    chk("release_ir", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_ov", {31'd0, out_valid}, 32'd1);
    chk("b2b_y", {24'd0, y}, 32'h03);
    tick();

    // Reset in the 4th busy cycle of a long iterative op.
`ifdef ALU_SEQ_MUL_EN
    opt = 4'd11; a = 8'h10; b = 8'h11;
`else
    opt = 4'd8; a = 8'h01; b = 8'h07;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("busy_ov", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rbusy_ov", {31'd0, out_valid}, 32'd0);
    chk("rbusy_y", {24'd0, y}, 32'd0);
    chk("rbusy_ir", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rbusy_stay", {31'd0, out_valid}, 32'd0);

    // Reset while a result waits with out_ready low.
    out_ready = 1'b0;
    issue(4'd4, 8'h0F, 8'h30);  expect_res("or_hold", 8'h3F, 4'b0000, 1'b0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rdone_ov", {31'd0, out_valid}, 32'd0);
    chk("rdone_y", {24'd0, y}, 32'd0);

    issue(4'd7, 8'h5A, 8'h5A);  expect_res("eq_t",    8'h01, 4'b0000, 1'b0, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width; legal values are powers of two, 4..32.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports in_valid (input, 1, request present) and in_ready (output, 1, block can accept).
REQ-006 The block SHALL have ports a and b, input, WIDTH, operands; opt, input, 4, operation code.
REQ-007 The block SHALL have ports out_valid (output, 1, result present) and out_ready (input, 1, consumer accepts).
REQ-008 The block SHALL have port y, output, WIDTH, result.
REQ-009 The block SHALL have port flags, output, 4, {negative, zero, carry, overflow}.
REQ-010 The block SHALL have port err, output, 1, illegal or disabled opcode.

Function
REQ-011 The block SHALL accept a request on an edge where in_valid && in_ready, capturing a, b and opt.
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL equal (IDLE) || (DONE && out_ready); out_valid SHALL equal DONE.
REQ-013 Opcodes SHALL be: 0 add, 1 sub, 2 ~a, 3 and, 4 or, 5 xor, 6 signed slt (y=1 iff a<b signed, from sign^overflow of a-b), 7 eq (y=1 iff a==b), 8 sll, 9 srl, 10 sra, 11 mul; 12..15 illegal.
REQ-014 Opcodes 0..7 and illegal opcodes SHALL go directly to DONE, with out_valid high on the cycle after acceptance.
REQ-015 Shifts SHALL use k=b[SHW-1:0], shift one bit per BUSY cycle and reach DONE k cycles after acceptance, or 1 cycle if k=0.
REQ-016 mul SHALL be unsigned shift-add, spend exactly WIDTH cycles from acceptance to DONE, and return the low WIDTH bits of the product.
REQ-017 In DONE the block SHALL hold y, flags and err stable until out_ready; on DONE && out_ready it SHALL go to IDLE, or directly restart if a new request is accepted on the same edge.
REQ-018 All arithmetic SHALL be modulo 2^WIDTH.
REQ-019 carry SHALL be: add = carry-out; sub and slt = 1 iff a>=b unsigned; shifts = last bit shifted out (0 if k=0); mul = 1 iff the upper product half is nonzero; otherwise 0.
REQ-020 overflow SHALL be signed overflow for add, sub and slt, and 0 otherwise.
REQ-021 zero SHALL equal (y==0) and negative SHALL equal y[WIDTH-1], for all opcodes.
REQ-022 An illegal opcode SHALL give y=0, flags=0100 and err=1; err SHALL be 0 for every legal opcode.
REQ-023 Inputs SHALL be ignored while BUSY; a and b may change after acceptance without affecting the result.

Reset
REQ-024 rst SHALL force state IDLE, y=0, flags=0, err=0, out_valid=0 and in_ready=1 on the next edge.
REQ-025 rst SHALL take priority over every other event, including mid-shift, mid-multiply and DONE with out_ready low; the in-flight result SHALL be discarded.

Configuration
REQ-026 With macro ALU_SEQ_MUL_EN defined, opcode 11 SHALL perform mul per REQ-016.
REQ-027 Without ALU_SEQ_MUL_EN, opcode 11 SHALL be illegal per REQ-022 with 1-cycle latency, and no multiplier datapath SHALL be synthesised.

Verification
REQ-028 WIDTH=8, add a=0x7F b=0x01 -> y=0x80, flags n1 z0 c0 v1, out_valid one cycle after accept.
REQ-029 WIDTH=8, sra a=0x90 b=0x03 -> y=0xF2, carry=0, out_valid exactly 3 cycles after accept; b=0x00 -> y=0x90 after 1 cycle.
REQ-030 WIDTH=8 with ALU_SEQ_MUL_EN, mul 0x10*0x11 -> y=0x10, carry=1, latency 8; same stimulus without the macro -> y=0, err=1, latency 1.
REQ-031 Hold out_ready=0 for 5 cycles after a sub of 0x03-0x05 -> y=0xFE, carry=0, stable throughout; in_ready=0 until out_ready=1, then back-to-back accept on that edge.
REQ-032 Assert rst during the 4th BUSY cycle of a mul -> next cycle IDLE, out_valid=0, y=0; a following eq 0x5A,0x5A -> y=1, zero=0.
